// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the binary sobel filter.
// Two line buffers plus a 3x3 shift register assemble every interior neighbourhood.
`timescale 1ns/1ps

module sobel_window_gen #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int CW     = $clog2(WIDTH),
   parameter int RW     = $clog2(HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_in,
   input  logic          pix_valid,
   input  logic          sof,
   output logic [8:0]    window,
   output logic          window_valid,
   output logic [RW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          frame_done
);

   // Handshake: pix_in/sof are taken on every rising edge with pix_valid=1; there is no
   // ready. window_valid and frame_done are single-cycle strobes, one per qualifying pixel.

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]    col, cur_c, col_next;
   logic [RW-1:0]    row, cur_r, row_next;
   logic [WIDTH-1:0] lb0, lb1;
   logic             top, mid;
   logic [8:0]       sr, sr_next;
   logic             issue, last_pix;

   // sof forces the accepted pixel to (0,0) regardless of where the counters are.
   always_comb begin
      cur_c    = sof ? '0 : col;
      cur_r    = sof ? '0 : row;
      top      = lb1[cur_c];
      mid      = lb0[cur_c];
      sr_next  = {pix_in, sr[8:7], mid, sr[5:4], top, sr[2:1]};
      issue    = pix_valid && (cur_r >= ROW_TWO) && (cur_c >= COL_TWO);
      last_pix = pix_valid && (cur_r == ROW_LAST) && (cur_c == COL_LAST);
      col_next = cur_c + COL_ONE;
      row_next = cur_r;
      if (cur_c == COL_LAST) begin
         col_next = '0;
         row_next = (cur_r == ROW_LAST) ? '0 : cur_r + ROW_ONE;
      end
   end

   // Line buffers are deliberately not reset: rows 0 and 1 are rewritten before any use.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb1[cur_c] <= lb0[cur_c];
         lb0[cur_c] <= pix_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
         sr  <= '0;
      end else if (pix_valid) begin
         col <= col_next;
         row <= row_next;
         sr  <= sr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window       <= '0;
         window_valid <= 1'b0;
         win_row      <= '0;
         win_col      <= '0;
         frame_done   <= 1'b0;
      end else begin
         window_valid <= issue;
         frame_done   <= last_pix;
         if (issue) begin
            window  <= sr_next;
            win_row <= cur_r - ROW_ONE;
            win_col <= cur_c - COL_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 instance for ordering, gaps, reset and
// implicit frames, and a 5x3 instance for the mid-frame sof case.
`timescale 1ns/1ps

module tb_sobel_window_gen;

   typedef struct {
      logic [15:0] pix;   // bit r*4+c is pixel (r,c)
      logic [35:0] exp;   // windows for centres (1,1),(1,2),(2,1),(2,2), lowest first
      bit          gaps;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pa = 1'b0, va = 1'b0, sa = 1'b0;
   logic pb = 1'b0, vb = 1'b0, sb = 1'b0;
   logic [8:0] wa, wb;
   logic       wva, wvb, fda, fdb;
   logic [1:0] ra, ca, rb;
   logic [2:0] cb;
   logic       acc_a = 1'b0, acc_b = 1'b0;

   int checks = 0;
   int errors = 0;
   int wcnt_a = 0, fd_a = 0, wcnt_b = 0, fd_b = 0;
   logic [15:0] exp_qa[$];
   logic [15:0] exp_qb[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   sobel_window_gen #(.WIDTH(4), .HEIGHT(4)) u_a (
      .clk(clk), .rst_n(rst_n), .pix_in(pa), .pix_valid(va), .sof(sa),
      .window(wa), .window_valid(wva), .win_row(ra), .win_col(ca), .frame_done(fda)
   );

   sobel_window_gen #(.WIDTH(5), .HEIGHT(3)) u_b (
      .clk(clk), .rst_n(rst_n), .pix_in(pb), .pix_valid(vb), .sof(sb),
      .window(wb), .window_valid(wvb), .win_row(rb), .win_col(cb), .frame_done(fdb)
   );

   function automatic logic [15:0] pk(input logic [2:0] r, input logic [2:0] c, input logic [8:0] w);
      return {1'b0, r, c, w};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Strobes seen at the falling edge belong to the pixel accepted at the previous rising edge.
   always @(posedge clk) begin
      acc_a <= va;
      acc_b <= vb;
   end

   always @(negedge clk) begin
      logic [15:0] e;
      if (wva) begin
         wcnt_a++;
         chk("strobe_a_without_pixel", int'(acc_a), 1);
         checks++;
         if (exp_qa.size() == 0) begin
            errors++;
            $display("FAIL win_a_extra: got 0x%0h, required no window", pk({1'b0, ra}, {1'b0, ca}, wa));
         end else begin
            e = exp_qa.pop_front();
            if (pk({1'b0, ra}, {1'b0, ca}, wa) != e) begin
               errors++;
               $display("FAIL win_a {row,col,win}: got 0x%0h, required 0x%0h",
                        pk({1'b0, ra}, {1'b0, ca}, wa), e);
            end
         end
      end
      if (fda) begin
         fd_a++;
         chk("frame_done_a_align", int'(acc_a && wva), 1);
      end
      if (wvb) begin
         wcnt_b++;
         chk("strobe_b_without_pixel", int'(acc_b), 1);
         checks++;
         if (exp_qb.size() == 0) begin
            errors++;
            $display("FAIL win_b_extra: got 0x%0h, required no window", pk({1'b0, rb}, cb, wb));
         end else begin
            e = exp_qb.pop_front();
            if (pk({1'b0, rb}, cb, wb) != e) begin
               errors++;
               $display("FAIL win_b {row,col,win}: got 0x%0h, required 0x%0h", pk({1'b0, rb}, cb, wb), e);
            end
         end
      end
      if (fdb) begin
         fd_b++;
         chk("frame_done_b_align", int'(acc_b && wvb), 1);
      end
   end

   task automatic drive_a(input logic p, input logic s);
      @(posedge clk); #1;
      va = 1'b1; pa = p; sa = s;
   endtask

   task automatic idle_a(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         va = 1'b0; sa = 1'b0;
      end
   endtask

   task automatic drive_b(input logic p, input logic s);
      @(posedge clk); #1;
      vb = 1'b1; pb = p; sb = s;
   endtask

   task automatic idle_b(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         vb = 1'b0; sb = 1'b0;
      end
   endtask

   task automatic push_exp_a(input logic [35:0] ex);
      for (int k = 0; k < 4; k++)
         exp_qa.push_back(pk(3'(1 + k / 2), 3'(1 + k % 2), ex[9*k +: 9]));
   endtask

   task automatic send_frame_a(input logic [15:0] pix, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         drive_a(pix[i], 1'b0);
         if (gaps) idle_a($urandom_range(0, 5));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{16'hFFFF, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, 1'b0};
      vecs[1] = '{16'h0001, {9'h000, 9'h000, 9'h000, 9'h001}, 1'b0};
      vecs[2] = '{16'h0400, {9'h010, 9'h020, 9'h080, 9'h100}, 1'b0};
      vecs[3] = '{16'h00F0, {9'h007, 9'h007, 9'h038, 9'h038}, 1'b0};
      vecs[4] = '{16'h8000, {9'h100, 9'h000, 9'h000, 9'h000}, 1'b0};
      vecs[5] = '{16'h0001, {9'h000, 9'h000, 9'h000, 9'h001}, 1'b1};
      vecs[6] = '{16'h0400, {9'h010, 9'h020, 9'h080, 9'h100}, 1'b1};

      // reset state
      #13;
      chk("rst_window", int'(wa), 0);
      chk("rst_window_valid", int'(wva), 0);
      chk("rst_win_row", int'(ra), 0);
      chk("rst_win_col", int'(ca), 0);
      chk("rst_frame_done", int'(fda), 0);
      chk("rst_b_outputs", int'({wb, wvb, rb, cb, fdb}), 0);
      #10 rst_n = 1'b1;

      // table-driven 4x4 frames, back-to-back or with random gaps
      foreach (vecs[v]) begin
         wcnt_a = 0;
         fd_a = 0;
         push_exp_a(vecs[v].exp);
         send_frame_a(vecs[v].pix, vecs[v].gaps);
         idle_a(3);
         chk($sformatf("vec%0d_win_count", v), wcnt_a, 4);
         chk($sformatf("vec%0d_frame_done_count", v), fd_a, 1);
         chk($sformatf("vec%0d_exp_left", v), exp_qa.size(), 0);
      end

      // asynchronous reset during row 2, right after the (2,2) window is issued
      for (int i = 0; i < 11; i++) drive_a(1'b1, 1'b0);
      @(posedge clk); #1;
      va = 1'b0;
      chk("pre_rst_window", int'(wa), 9'h1FF);
      chk("pre_rst_valid", int'(wva), 1);
      chk("pre_rst_centre", int'({ra, ca}), 4'b0101);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_window", int'(wa), 0);
      chk("async_rst_valid", int'(wva), 0);
      chk("async_rst_centre", int'({ra, ca}), 0);
      chk("async_rst_frame_done", int'(fda), 0);
      #3 rst_n = 1'b1;

      // three frames back-to-back, no sof: first starts at (0,0) after reset
      wcnt_a = 0;
      fd_a = 0;
      push_exp_a({9'h000, 9'h000, 9'h000, 9'h001});
      push_exp_a({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});
      push_exp_a({9'h100, 9'h000, 9'h000, 9'h000});
      send_frame_a(16'h0001, 1'b0);
      send_frame_a(16'hFFFF, 1'b0);
      send_frame_a(16'h8000, 1'b0);
      idle_a(3);
      chk("multi_win_count", wcnt_a, 12);
      chk("multi_frame_done_count", fd_a, 3);
      chk("multi_exp_left", exp_qa.size(), 0);

      // 5x3: sof on the 7th pixel abandons the first frame
      exp_qb.push_back(pk(3'd1, 3'd1, 9'h1FF));
      exp_qb.push_back(pk(3'd1, 3'd2, 9'h1FF));
      exp_qb.push_back(pk(3'd1, 3'd3, 9'h1FF));
      for (int i = 0; i < 6; i++) drive_b(1'b1, 1'b0);
      drive_b(1'b1, 1'b1);
      for (int i = 1; i < 15; i++) drive_b(1'b1, 1'b0);
      @(negedge clk);
      chk("sof_no_early_frame_done", fd_b, 0);
      idle_b(3);
      chk("sof_frame_done_count", fd_b, 1);
      chk("sof_win_count", wcnt_b, 3);
      chk("sof_exp_left", exp_qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that feeds the binary `sobel` filter. It accepts a raster-order stream of 1-bit pixels, one pixel per cycle at most. Two line buffers and a 3x3 shift register assemble the 9-bit neighbourhood around every interior pixel, and each window is presented in the bit order the filter consumes. It sits between the binarised pixel source and the `sobel` instance.

## Interface
Parameters:
- `WIDTH`, default 640: pixels per line. Legal range is 3 and up.
- `HEIGHT`, default 480: lines per frame. Legal range is 3 and up.
- `CW`, default `$clog2(WIDTH)`: width of the column counter and `win_col`.
- `RW`, default `$clog2(HEIGHT)`: width of the row counter and `win_row`.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pix_in`, input, 1: binary pixel.
- `pix_valid`, input, 1: `pix_in` is accepted on a rising edge where this is 1. There is no backpressure.
- `sof`, input, 1: start of frame. Sampled only when `pix_valid`=1. The accepted pixel is at position (0,0).
- `window`, output, 9: 3x3 neighbourhood. Bit `3*r+c` holds row r (0 = oldest line) and column c (0 = leftmost).
- `window_valid`, output, 1: one-cycle strobe per window.
- `win_row`, output, RW: row of the window centre pixel.
- `win_col`, output, CW: column of the window centre pixel.
- `frame_done`, output, 1: one-cycle strobe after the last pixel of a frame.

## Operation
- The column counter `col` and row counter `row` give the position of the next accepted pixel.
  - On each accepted pixel, `col` increments.
  - At `WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At (`HEIGHT-1`, `WIDTH-1`), both counters wrap to 0. The next frame is implicit and needs no `sof`.
- An accepted pixel with `sof`=1 is treated as position (0,0), whatever the counter state. The counters then continue from (0,1).
- Line buffers `lb0` and `lb1` are WIDTH bits each, indexed by column. `lb0` holds line row-1 and `lb1` holds line row-2. For an accepted pixel p at (r,c):
  - Read `top`=`lb1[c]` and `mid`=`lb0[c]`; the bottom value is p.
  - Write `lb1[c]`<=`lb0[c]` and `lb0[c]`<=p.
  - Shift the window columns: column 0 takes column 1, column 1 takes column 2, and column 2 takes {top, mid, p}. Column 2 holds bits 2, 5 and 8 respectively.
- Window bit positions after that pixel is shifted in:
  - Bit 0 = pixel (r-2, c-2).
  - Bit 2 = pixel (r-2, c).
  - Bit 6 = pixel (r, c-2).
  - Bit 8 = pixel (r, c).
- A window is issued only when r≥2 and c≥2. There is no border padding, so each frame produces exactly (WIDTH-2)*(HEIGHT-2) windows.
  - With that window, `win_row`=r-1 and `win_col`=c-1.
  - At c=0 and c=1 the shift register contains data from the previous line's tail. It is never issued.
- Line buffers are never cleared, including at reset. Stale contents are never issued, because rows 0 and 1 are rewritten before any window uses them.
- `frame_done` pulses for the pixel at (`HEIGHT-1`, `WIDTH-1`).
- A `sof` in the middle of a frame abandons the current frame. It produces no `frame_done` for that frame. Counters restart as described above.

## Timing
- All outputs are registered.
- Latency: `window`, `window_valid`, `win_row` and `win_col` update on the rising edge that accepts the completing pixel. They are visible in the following cycle.
- `window_valid` and `frame_done` are high for exactly one cycle per qualifying accepted pixel.
  - With back-to-back valid pixels they stay high on consecutive cycles.
  - When `pix_valid`=0 they are 0.
- `window`, `win_row` and `win_col` hold their last value between strobes.
- `pix_valid`=0 changes no state. Gaps of any length are transparent.
- Reset values: `window`=9'h000, `window_valid`=0, `win_row`=0, `win_col`=0, `frame_done`=0. Counters and the shift register reset to 0.
- Reset asserted mid-frame clears outputs immediately, without waiting for the clock. The first pixel accepted after release is (0,0), with or without `sof`.
- Throughput: 1 pixel per cycle sustained.

## Test plan
- **All-ones frame.** WIDTH=4, HEIGHT=4, 16 pixels of 1, back-to-back.
  - Exactly 4 windows, all 9'h1FF.
  - Centres (1,1), (1,2), (2,1), (2,2), in that order.
  - `frame_done` pulses once, in the cycle after pixel 15.
- **Bit ordering.** WIDTH=4, HEIGHT=4, single 1 at (0,0), all other pixels 0.
  - Window at (1,1) = 9'h001; the other windows = 9'h000.
  - Repeat with the single 1 at (2,2): window at (1,1) = 9'h100 and window at (2,2) = 9'h010.
- **Gaps.** Same stimulus as the ordering test, with random `pix_valid` gaps of 0-5 cycles.
  - Identical window sequence.
  - `window_valid` count = 4.
  - No strobe during a gap.
- **Mid-frame `sof`.** WIDTH=5, HEIGHT=3. Assert `sof` on the 7th pixel, then send 15 pixels.
  - No `frame_done` for the first frame.
  - Next 3 windows have centres (1,1), (1,2), (1,3).
  - `frame_done` fires after the 15th pixel.
- **Reset mid-frame.** Assert `rst_n`=0 asynchronously during row 2.
  - Outputs go to 0 before the next edge.
  - After release, a full frame sent without `sof` yields a correct all-ones/ordering result.
- **Implicit next frame.** Send two 4x4 frames back-to-back with no `sof`.
  - 8 windows and 2 `frame_done` pulses.
  - The second frame's windows depend only on second-frame pixels.
